// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// muldiv_pkg
// Shared op/state encodings and operand-signedness helpers for the RV32M unit.
// Revision: 1.0
// ============================================================================
package muldiv_pkg;

    localparam int MUL_CNT_W = 3;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic logic is_signed_a(input op_t f);
        return f inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input op_t f);
        return f inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_rv32m_div_core.sv
`default_nettype none
// ============================================================================
// muldiv_div_core
// Iterative restoring divider on unsigned magnitudes, one quotient bit/cycle.
// Revision: 1.0
// ============================================================================
module muldiv_div_core #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  kill,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  done
);
    localparam int CNT_W = $clog2(DATA_WIDTH);

    logic                  r_busy;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_quo;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_divisor;
    logic [DATA_WIDTH:0]   w_shift;
    logic [DATA_WIDTH:0]   w_trial;

    // Quotient register doubles as the dividend shift register.
    assign w_shift = {r_rem, r_quo[DATA_WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_divisor};
    assign done    = r_busy && (r_cnt == CNT_W'(DATA_WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
        end else if (kill) begin
            r_busy <= 1'b0;
        end else if (start) begin
            r_busy    <= 1'b1;
            r_cnt     <= '0;
            r_quo     <= dividend;
            r_rem     <= '0;
            r_divisor <= divisor;
        end else if (r_busy) begin
            if (!w_trial[DATA_WIDTH]) begin
                r_rem <= w_trial[DATA_WIDTH-1:0];
                r_quo <= {r_quo[DATA_WIDTH-2:0], 1'b1};
            end else begin
                r_rem <= w_shift[DATA_WIDTH-1:0];
                r_quo <= {r_quo[DATA_WIDTH-2:0], 1'b0};
            end
            r_cnt <= r_cnt + CNT_W'(1);
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit_rv32m.sv
`default_nettype none
// ============================================================================
// muldiv_unit_rv32m
// Multi-cycle RV32M execute unit (MUL/MULH*/DIV*/REM*) with valid/ready + stall.
// Optional: MULDIV_DIV_EARLY_OUT_EN skips divide iterations when |A| < |B|.
// Revision: 1.0
// ============================================================================
module muldiv_unit_rv32m
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] operand_A,
    input  logic [DATA_WIDTH-1:0] operand_B,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic                  hold_pipeline,
    output logic                  div_by_zero
);
    localparam logic [DATA_WIDTH-1:0] c_most_neg = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t                 r_state,  w_state_next;
    op_t                    r_op,     w_op_next;
    logic [MUL_CNT_W-1:0]   r_cnt,    w_cnt_next;
    logic [DATA_WIDTH-1:0]  r_a,      w_a_next;
    logic [DATA_WIDTH-1:0]  r_b,      w_b_next;
    logic                   r_sa,     w_sa_next;
    logic                   r_sb,     w_sb_next;
    logic [DATA_WIDTH-1:0]  r_result, w_result_next;
    logic                   r_dbz,    w_dbz_next;
    logic                   w_div_start;

    op_t                    w_op_in;
    logic                   w_sa_in;
    logic                   w_sb_in;
    logic [DATA_WIDTH-1:0]  w_mag_a;
    logic [DATA_WIDTH-1:0]  w_mag_b;
    logic                   w_b_zero;
    logic                   w_ovf;
    logic [DATA_WIDTH-1:0]  w_div_quo;
    logic [DATA_WIDTH-1:0]  w_div_rem;
    logic                   w_div_done;
    logic [DATA_WIDTH-1:0]  w_q_mag;
    logic [DATA_WIDTH-1:0]  w_r_mag;
    logic [DATA_WIDTH-1:0]  w_q_res;
    logic [DATA_WIDTH-1:0]  w_r_res;

    function automatic logic [DATA_WIDTH-1:0] mul_calc(
        input op_t                   f,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [2*DATA_WIDTH-1:0] ae;
        logic [2*DATA_WIDTH-1:0] be;
        logic [2*DATA_WIDTH-1:0] p;
        ae = is_signed_a(f) ? {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a} : {{DATA_WIDTH{1'b0}}, a};
        be = is_signed_b(f) ? {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b} : {{DATA_WIDTH{1'b0}}, b};
        p  = ae * be;
        return (f == OP_MUL) ? p[DATA_WIDTH-1:0] : p[2*DATA_WIDTH-1:DATA_WIDTH];
    endfunction

    assign w_op_in  = op_t'(op);
    assign w_sa_in  = is_signed_a(w_op_in) & operand_A[DATA_WIDTH-1];
    assign w_sb_in  = is_signed_b(w_op_in) & operand_B[DATA_WIDTH-1];
    assign w_mag_a  = w_sa_in ? -operand_A : operand_A;
    assign w_mag_b  = w_sb_in ? -operand_B : operand_B;
    assign w_b_zero = (operand_B == '0);
    assign w_ovf    = is_signed_a(w_op_in) && (operand_A == c_most_neg) && (&operand_B);

    muldiv_div_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .kill      (flush),
        .start     (w_div_start),
        .dividend  (w_mag_a),
        .divisor   (w_mag_b),
        .quotient  (w_div_quo),
        .remainder (w_div_rem),
        .done      (w_div_done)
    );

`ifdef MULDIV_DIV_EARLY_OUT_EN
    logic                  r_early,  w_early_next;
    logic [DATA_WIDTH-1:0] r_mag_a,  w_mag_a_next;

    assign w_q_mag = r_early ? '0 : w_div_quo;
    assign w_r_mag = r_early ? r_mag_a : w_div_rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_early <= 1'b0;
            r_mag_a <= '0;
        end else begin
            r_early <= w_early_next;
            r_mag_a <= w_mag_a_next;
        end
    end
`else
    assign w_q_mag = w_div_quo;
    assign w_r_mag = w_div_rem;
`endif

    assign w_q_res = (r_sa ^ r_sb) ? -w_q_mag : w_q_mag;
    assign w_r_res = r_sa ? -w_r_mag : w_r_mag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_MUL;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_result <= '0;
            r_dbz    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_op     <= w_op_next;
            r_cnt    <= w_cnt_next;
            r_a      <= w_a_next;
            r_b      <= w_b_next;
            r_sa     <= w_sa_next;
            r_sb     <= w_sb_next;
            r_result <= w_result_next;
            r_dbz    <= w_dbz_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_op_next     = r_op;
        w_cnt_next    = r_cnt;
        w_a_next      = r_a;
        w_b_next      = r_b;
        w_sa_next     = r_sa;
        w_sb_next     = r_sb;
        w_result_next = r_result;
        w_dbz_next    = r_dbz;
        w_div_start   = 1'b0;
`ifdef MULDIV_DIV_EARLY_OUT_EN
        w_early_next  = r_early;
        w_mag_a_next  = r_mag_a;
`endif
        if (flush) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
            w_dbz_next   = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_valid) begin
                        w_op_next = w_op_in;
                        w_a_next  = operand_A;
                        w_b_next  = operand_B;
                        w_sa_next = w_sa_in;
                        w_sb_next = w_sb_in;
`ifdef MULDIV_DIV_EARLY_OUT_EN
                        w_early_next = 1'b0;
                        w_mag_a_next = w_mag_a;
`endif
                        if (!op[2]) begin
                            // The accept cycle counts toward the latency, so a
                            // one-cycle multiply resolves directly at accept.
                            if (MUL_LATENCY == 1) begin
                                w_result_next = mul_calc(w_op_in, operand_A, operand_B);
                                w_state_next  = ST_DONE;
                            end else begin
                                w_cnt_next   = MUL_CNT_W'(1);
                                w_state_next = ST_MUL;
                            end
                        end else if (w_b_zero) begin
                            w_result_next = op[1] ? operand_A : '1;
                            w_dbz_next    = 1'b1;
                            w_state_next  = ST_DONE;
                        end else if (w_ovf) begin
                            w_result_next = op[1] ? '0 : operand_A;
                            w_state_next  = ST_DONE;
                        end
`ifdef MULDIV_DIV_EARLY_OUT_EN
                        else if (w_mag_a < w_mag_b) begin
                            w_early_next = 1'b1;
                            w_state_next = ST_FIX;
                        end
`endif
                        else begin
                            w_div_start  = 1'b1;
                            w_state_next = ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    if (r_cnt == MUL_CNT_W'(MUL_LATENCY - 1)) begin
                        w_result_next = mul_calc(r_op, r_a, r_b);
                        w_cnt_next    = '0;
                        w_state_next  = ST_DONE;
                    end else begin
                        w_cnt_next = r_cnt + MUL_CNT_W'(1);
                    end
                end
                ST_DIV: begin
                    if (w_div_done) begin
                        w_state_next = ST_FIX;
                    end
                end
                ST_FIX: begin
                    w_result_next = (r_op inside {OP_REM, OP_REMU}) ? w_r_res : w_q_res;
                    w_state_next  = ST_DONE;
                end
                ST_DONE: begin
                    if (result_ready) begin
                        w_dbz_next   = 1'b0;
                        w_state_next = ST_IDLE;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign start_ready   = (r_state == ST_IDLE);
    assign result_valid  = (r_state == ST_DONE);
    assign result        = r_result;
    assign div_by_zero   = r_dbz;
    assign hold_pipeline = ((r_state == ST_IDLE) && start_valid) ||
                           (r_state inside {ST_MUL, ST_DIV, ST_FIX});

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit_rv32m.sv
`default_nettype none
// ============================================================================
// tb_muldiv_unit_rv32m
// Randomized + directed bench against an arithmetic reference model.
// Revision: 1.0
// ============================================================================
module tb_muldiv_unit_rv32m;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          start_valid;
    logic          start_ready;
    logic [2:0]    op;
    logic [DW-1:0] operand_A;
    logic [DW-1:0] operand_B;
    logic [DW-1:0] result;
    logic          result_valid;
    logic          result_ready;
    logic          hold_pipeline;
    logic          div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    muldiv_unit_rv32m #(
        .DATA_WIDTH  (DW),
        .MUL_LATENCY (LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .start_valid   (start_valid),
        .start_ready   (start_ready),
        .op            (op),
        .operand_A     (operand_A),
        .operand_B     (operand_B),
        .result        (result),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .hold_pipeline (hold_pipeline),
        .div_by_zero   (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // RISC-V M semantics computed with 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub, q;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                q = sa / sb; return q[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                q = ua / ub; return q[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                q = sa % sb; return q[31:0];
            end
            default: begin
                if (b == 0) return a;
                q = ua % ub; return q[31:0];
            end
        endcase
    endfunction

    // Cycles from the accept edge until result_valid is seen.
    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ma, mb;
        logic   sgn;
        if (!f[2]) return LAT;
        sgn = (f == 3'd4) || (f == 3'd6);
        if (b == 0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        sa = $signed(a);
        sb = $signed(b);
        ma = sgn ? ((sa < 0) ? -sa : sa) : longint'({32'd0, a});
        mb = sgn ? ((sb < 0) ? -sb : sb) : longint'({32'd0, b});
`ifdef MULDIV_DIV_EARLY_OUT_EN
        if (ma < mb) return 2;
`else
        if (ma < mb) return DW + 2;
`endif
        return DW + 2;
    endfunction

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op          = f;
        operand_A   = a;
        operand_B   = b;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int bp);
        int          cyc;
        logic        hold_ok;
        logic        stable_ok;
        logic [31:0] exp_r;
        exp_r = ref_result(f, a, b);
        issue(f, a, b);
        cyc     = 1;
        hold_ok = 1'b1;
        while (!result_valid && cyc < 100) begin
            if (!hold_pipeline) hold_ok = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        check($sformatf("latency op%0d", f), 64'(cyc), 64'(ref_latency(f, a, b)));
        check("hold_busy", 64'(hold_ok), 64'd1);
        check($sformatf("result op%0d %h %h", f, a, b), 64'(result), 64'(exp_r));
        check("div_by_zero", 64'(div_by_zero), 64'(f[2] && (b == 0)));
        check("hold_done", 64'(hold_pipeline), 64'd0);
        if (bp > 0) begin
            stable_ok = 1'b1;
            for (int i = 0; i < bp; i++) begin
                @(posedge clk);
                #1;
                if (!result_valid || result !== exp_r || start_ready) stable_ok = 1'b0;
            end
            check("backpressure", 64'(stable_ok), 64'd1);
        end
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        check("release", 64'({result_valid, start_ready, div_by_zero}), 64'b010);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic ok;
        rst          = 1'b1;
        flush        = 1'b0;
        start_valid  = 1'b0;
        result_ready = 1'b0;
        op           = 3'd0;
        operand_A    = '0;
        operand_B    = '0;
        repeat (2) @(negedge clk);
        check("reset_state", 64'({result, result_valid, div_by_zero, start_ready, hold_pipeline}), 64'b0010);
        rst = 1'b0;

        // Directed cases
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd5, 32'h1234_5678, 32'd0, 0);
        run_op(3'd7, 32'h1234_5678, 32'd0, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd5, 32'd3, 32'd10, 0);
        run_op(3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 5);

        // Flush in IDLE blocks the accept
        @(negedge clk);
        op = 3'd0; operand_A = 32'd3; operand_B = 32'd4;
        start_valid = 1'b1;
        flush       = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        flush       = 1'b0;
        check("flush_blocks_accept", 64'({start_ready, result_valid}), 64'b10);

        // Flush mid-divide
        issue(3'd4, 32'd1000, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_idle", 64'({result_valid, start_ready, hold_pipeline}), 64'b010);
        ok = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (result_valid) ok = 1'b0;
        end
        check("flush_no_result", 64'(ok), 64'd1);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

        // Asynchronous reset mid-divide, observed before the next edge
        issue(3'd5, 32'hDEAD_BEEF, 32'd3);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset", 64'({result, result_valid, div_by_zero, start_ready, hold_pipeline}), 64'b0010);
        @(negedge clk);
        rst = 1'b0;
        run_op(3'd7, 32'd100, 32'd7, 0);

        // Randomized operations
        for (int i = 0; i < 60; i++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick(), int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit_rv32m.md
Name: muldiv_unit_rv32m

Overview:
- Multi-cycle M-extension execute unit sitting beside the RV32IM ALU in EX stage.
- Executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU on rs1/rs2 operands.
- Valid/ready handshake on issue and result; raises hold_pipeline to stall the pipeline while busy.
- Generalised in width and multiply latency.

Parameters:
- DATA_WIDTH, 32, operand/result width; even and >= 8.
- MUL_LATENCY, 2, cycles from accept edge to result_valid for multiply ops; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of the in-flight op (branch/JALR redirect).
- start_valid  in  1  issue request.
- start_ready  out  1  unit can accept; high only in IDLE.
- op  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand_A  in  DATA_WIDTH  rs1.
- operand_B  in  DATA_WIDTH  rs2.
- result  out  DATA_WIDTH  registered result; stable while result_valid.
- result_valid  out  1  result available.
- result_ready  in  1  consumer takes result.
- hold_pipeline  out  1  stall request to the pipeline.
- div_by_zero  out  1  sticky-per-result flag: current result came from a zero divisor.

Behaviour:
- Reset (async, rst high): state IDLE; result=0; result_valid=0; div_by_zero=0; counter=0; start_ready=1; hold_pipeline=0.
- States: IDLE, MUL, DIV, FIX, DONE.
- Accept: start_valid & start_ready at edge E0; operands and op are latched.
  - op[2]=0 -> MUL.
  - op[2]=1, special case -> DONE.
  - Otherwise DIV; absolute values are taken at E0 for signed ops, with sign bits recorded.
- Multiply:
  - Full 2*DATA_WIDTH product; sign handling per op (MULHSU: A signed, B unsigned).
  - MUL returns the low half; the others return the high half.
  - Counter reaches MUL_LATENCY-1, then DONE.
  - result_valid rises MUL_LATENCY cycles after E0.
- Divide:
  - Restoring, 1 quotient bit per cycle, DATA_WIDTH iterations in DIV, then one FIX cycle that applies signs.
  - Quotient sign = sA^sB; remainder sign = sA.
  - result_valid rises DATA_WIDTH+2 cycles after E0.
- Special cases resolved at accept, with result_valid one cycle after E0:
  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> operand_A; div_by_zero=1.
  - Signed overflow (A = most negative, B = -1): DIV -> operand_A; REM -> 0.
- DONE:
  - result_valid=1; result held until result_ready.
  - On result_ready -> IDLE, result_valid=0, div_by_zero=0.
  - No new accept in the same cycle; start_ready stays low in DONE.
- hold_pipeline = (IDLE & start_valid) | MUL | DIV | FIX. It is low in DONE so the instruction can retire.
- flush:
  - From any non-IDLE state -> IDLE at the next edge; result_valid=0; no result is produced.
  - flush in IDLE blocks an accept in that same cycle.
  - flush has priority over result_ready.
- Unknown/illegal combinations do not exist: all 8 op codes are defined.
- Reset mid-operation: immediate return to reset values; no partial result is visible.

Optional Feature:
- Macro: MULDIV_DIV_EARLY_OUT_EN.
- Defined: at accept, if |A| < |B| (unsigned compare of the magnitudes), skip the DIV iterations and go straight to FIX with quotient=0 and remainder=|A|; result_valid 2 cycles after E0.
- Undefined: always the full DATA_WIDTH iterations; latency is fixed and data-independent.

Decomposition:
- Package muldiv_pkg:
  - op enum (the 8 funct3 codes).
  - state enum.
  - helper function is_signed_a/is_signed_b(op).
- Sub-module muldiv_div_core: iterative restoring divider (magnitudes in, quotient/remainder out, start/done). The multiplier stays inline.

Test Plan:
- MULH: A=0x80000000, B=0x80000000 -> result 0x40000000, result_valid exactly MUL_LATENCY cycles after accept; MUL of the same operands -> 0x00000000.
- DIV: A=-7 (0xFFFFFFF9), B=2 -> 0xFFFFFFFD after 34 cycles; REM -> 0xFFFFFFFF; hold_pipeline high throughout, low in DONE.
- DIVU: A=0x12345678, B=0 -> result 0xFFFFFFFF with div_by_zero=1 one cycle after accept; REMU -> 0x12345678.
- DIV: A=0x80000000, B=0xFFFFFFFF -> 0x80000000; REM -> 0; no iterations performed.
- Backpressure and flush:
  - Hold result_ready=0 for 5 cycles -> result stable and start_ready=0 throughout.
  - Assert flush at iteration 10 of a DIV -> IDLE next cycle, no result_valid.
  - A new MULHU 0xFFFFFFFF*0xFFFFFFFF then returns 0xFFFFFFFE.
- Async reset pulse mid-DIV -> all outputs at reset values without waiting for a clock edge; with MULDIV_DIV_EARLY_OUT_EN, DIVU 3/10 -> 0 in 2 cycles.
